// File: rtl/dcm_clkgen_programmer.sv
// Purpose: drives the DCM_CLKGEN serial PROG port (LoadD, LoadM, GO) and waits for PROGDONE.
// Latency: a legal start yields LoadD bits on edges 1..10, GO on edge 9+2*GAP_CYCLES+12, done 3 edges after PROGDONE rises.
// Backpressure: none; a start while busy (or while an error is pending) is dropped, never queued.
//
// Ports:
//   i_clock      block clock, also the DCM PROGCLK
//   i_reset_n    asynchronous active-low reset
//   i_start      single-cycle request, only honoured in IDLE
//   i_multiply   requested M (2..255)
//   i_divide     requested D (1..255)
//   i_progdone   DCM PROGDONE (asynchronous to us, synchronized here)
//   o_progen     DCM PROGEN
//   o_progdata   DCM PROGDATA
//   o_busy       transaction in progress
//   o_done       one-cycle pulse on successful completion
//   o_error      one-cycle pulse on an illegal request or a PROGDONE timeout
module dcm_clkgen_programmer #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [7:0] i_multiply,
  input  logic [7:0] i_divide,
  input  logic       i_progdone,
  output logic       o_progen,
  output logic       o_progdata,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_D,
    S_GAP1,
    S_LOAD_M,
    S_GAP2,
    S_GO,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sync1;
  logic             r_sync2;
  logic [7:0]       r_dv;
  logic [7:0]       r_mv;
  logic [3:0]       r_bit_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_bad_req;

  logic             w_req_legal;
  logic             w_accept;
  logic             w_bit_last;
  logic             w_gap_last;
  logic             w_timeout;
  logic [9:0]       w_frame_d;
  logic [9:0]       w_frame_m;

  logic             w_progen_nxt;
  logic             w_progdata_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_error_nxt;

  assign w_req_legal = (i_multiply >= 8'd2) && (i_divide != 8'd0);
  // Requests are blocked while an illegal-request error is still waiting to
  // be pulsed, so the next start is taken on the edge after the error.
  assign w_accept    = (r_state == S_IDLE) && i_start && !r_bad_req;
  assign w_bit_last  = (r_bit_cnt == 4'd9);
  assign w_gap_last  = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign w_timeout   = (r_to_cnt >= TO_W'(TIMEOUT));

  // Frames are shifted out bit 0 first: two command bits, then the payload LSB first.
  assign w_frame_d   = {r_dv, 1'b0, 1'b1};
  assign w_frame_m   = {r_mv, 1'b1, 1'b1};

  // PROGDONE comes from the DCM's own logic; two flops before use.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_progdone;
      r_sync2 <= r_sync1;
    end
  end

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_accept && w_req_legal) w_state_nxt = S_LOAD_D;
      S_LOAD_D:    if (w_bit_last) w_state_nxt = S_GAP1;
      S_GAP1:      if (w_gap_last) w_state_nxt = S_LOAD_M;
      S_LOAD_M:    if (w_bit_last) w_state_nxt = S_GAP2;
      S_GAP2:      if (w_gap_last) w_state_nxt = S_GO;
      S_GO:        w_state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (w_timeout)     w_state_nxt = S_IDLE;
        else if (!r_sync2) w_state_nxt = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (r_sync2 || w_timeout) w_state_nxt = S_IDLE;
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Captured request, bit/gap counters and the GO-to-PROGDONE timeout counter.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dv      <= 8'd0;
      r_mv      <= 8'd0;
      r_bit_cnt <= 4'd0;
      r_gap_cnt <= '0;
      r_to_cnt  <= '0;
      r_bad_req <= 1'b0;
    end else begin
      r_bad_req <= w_accept && !w_req_legal;

      if (w_accept && w_req_legal) begin
        r_dv <= i_divide - 8'd1;
        r_mv <= i_multiply - 8'd1;
      end

      if ((r_state == S_LOAD_D) || (r_state == S_LOAD_M)) begin
        r_bit_cnt <= w_bit_last ? 4'd0 : r_bit_cnt + 4'd1;
      end else begin
        r_bit_cnt <= 4'd0;
      end

      if ((r_state == S_GAP1) || (r_state == S_GAP2)) begin
        r_gap_cnt <= w_gap_last ? '0 : r_gap_cnt + GAP_W'(1);
      end else begin
        r_gap_cnt <= '0;
      end

      // Runs from GO through both wait states and saturates at TIMEOUT.
      if ((r_state == S_GO) || (r_state == S_WAIT_LOW) || (r_state == S_WAIT_HIGH)) begin
        if (!w_timeout) r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // Output decode; the values are registered below so every output is a flop.
  always_comb begin
    w_progen_nxt   = 1'b0;
    w_progdata_nxt = 1'b0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_error_nxt    = r_bad_req;
    case (r_state)
      S_LOAD_D: begin
        w_progen_nxt   = 1'b1;
        w_progdata_nxt = w_frame_d[r_bit_cnt];
        w_busy_nxt     = 1'b1;
      end
      S_LOAD_M: begin
        w_progen_nxt   = 1'b1;
        w_progdata_nxt = w_frame_m[r_bit_cnt];
        w_busy_nxt     = 1'b1;
      end
      S_GAP1, S_GAP2: begin
        w_busy_nxt = 1'b1;
      end
      S_GO: begin
        w_progen_nxt = 1'b1;
        w_busy_nxt   = 1'b1;
      end
      S_WAIT_LOW: begin
        w_busy_nxt  = !w_timeout;
        w_error_nxt = w_timeout;
      end
      S_WAIT_HIGH: begin
        // A PROGDONE arriving on the timeout cycle still counts as success.
        if (r_sync2) begin
          w_done_nxt = 1'b1;
        end else if (w_timeout) begin
          w_error_nxt = 1'b1;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_progen   <= 1'b0;
      o_progdata <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      o_progen   <= w_progen_nxt;
      o_progdata <= w_progdata_nxt;
      o_busy     <= w_busy_nxt;
      o_done     <= w_done_nxt;
      o_error    <= w_error_nxt;
    end
  end

endmodule

// File: tb/tb_dcm_clkgen_programmer.sv
module tb_dcm_clkgen_programmer;

  localparam int TO   = 4096;
  localparam int NREC = 4300;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] multiply;
  logic [7:0] divide;
  logic       progdone;
  logic       progen;
  logic       progdata;
  logic       busy;
  logic       done;
  logic       error;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic rec_progen   [0:NREC-1];
  logic rec_progdata [0:NREC-1];
  logic rec_busy     [0:NREC-1];
  logic rec_done     [0:NREC-1];
  logic rec_error    [0:NREC-1];

  always #5 clock = ~clock;

  dcm_clkgen_programmer #(
    .GAP_CYCLES(2),
    .TIMEOUT   (TO)
  ) dut (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_start   (start),
    .i_multiply(multiply),
    .i_divide  (divide),
    .i_progdone(progdone),
    .o_progen  (progen),
    .o_progdata(progdata),
    .o_busy    (busy),
    .o_done    (done),
    .o_error   (error)
  );

  task automatic do_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    progdone = 1'b1;
    multiply = 8'd4;
    divide   = 8'd1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Start is sampled at edge 0; outputs recorded #1 after edges 1..n.
  // progdone changes just after edges drop_e / rise_e; extra start pulses are
  // sampled at edges p1 / p2; hold keeps start high throughout.
  task automatic run_txn(input logic [7:0] m, input logic [7:0] d, input int n,
                         input int drop_e, input int rise_e, input int p1,
                         input int p2, input bit hold);
    multiply = m;
    divide   = d;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = hold;
    multiply = 8'hC3;
    divide   = 8'h3C;
    for (int e = 1; e <= n; e++) begin
      @(posedge clock);
      #1;
      rec_progen[e]   = progen;
      rec_progdata[e] = progdata;
      rec_busy[e]     = busy;
      rec_done[e]     = done;
      rec_error[e]    = error;
      if (e == drop_e) progdone = 1'b0;
      if (e == rise_e) progdone = 1'b1;
      start = hold || (e + 1 == p1) || (e + 1 == p2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if (progen   !== 1'b0) $display("FAIL reset_progen got %b want 0", progen);     else pass_cnt++;
    chk_cnt++; if (progdata !== 1'b0) $display("FAIL reset_progdata got %b want 0", progdata); else pass_cnt++;
    chk_cnt++; if (busy     !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);         else pass_cnt++;
    chk_cnt++; if (done     !== 1'b0) $display("FAIL reset_done got %b want 0", done);         else pass_cnt++;
    chk_cnt++; if (error    !== 1'b0) $display("FAIL reset_error got %b want 0", error);       else pass_cnt++;
  endtask

  // M=4, D=1: LoadD 1,0,0x00 ; LoadM 1,1,0x03 (bit 0 of each vector is sent first).
  task automatic test_basic();
    logic [9:0] fd;
    logic [9:0] fm;
    logic pe, pd;
    fd = 10'b0000000001;
    fm = 10'b0000001111;
    do_reset();
    run_txn(8'd4, 8'd1, 90, 27, 77, -1, -1, 1'b0);
    for (int e = 1; e <= 90; e++) begin
      pe = ((e >= 1) && (e <= 10)) || ((e >= 13) && (e <= 22)) || (e == 25);
      pd = 1'b0;
      if (e <= 10) pd = fd[e-1];
      else if ((e >= 13) && (e <= 22)) pd = fm[e-13];
      chk_cnt++; if (rec_progen[e] !== pe) $display("FAIL basic_progen edge %0d got %b want %b", e, rec_progen[e], pe); else pass_cnt++;
      chk_cnt++; if (rec_progdata[e] !== pd) $display("FAIL basic_progdata edge %0d got %b want %b", e, rec_progdata[e], pd); else pass_cnt++;
      chk_cnt++; if (rec_busy[e] !== (e < 80)) $display("FAIL basic_busy edge %0d got %b want %b", e, rec_busy[e], (e < 80)); else pass_cnt++;
      chk_cnt++; if (rec_done[e] !== (e == 80)) $display("FAIL basic_done edge %0d got %b want %b", e, rec_done[e], (e == 80)); else pass_cnt++;
      chk_cnt++; if (rec_error[e] !== 1'b0) $display("FAIL basic_error edge %0d got %b want 0", e, rec_error[e]); else pass_cnt++;
    end
  endtask

  // M=255, D=255: both payloads 0xFE.
  task automatic test_max();
    logic [9:0] fd;
    logic [9:0] fm;
    logic pe, pd;
    fd = 10'b1111111001;
    fm = 10'b1111111011;
    do_reset();
    run_txn(8'd255, 8'd255, 40, 27, 32, -1, -1, 1'b0);
    for (int e = 1; e <= 26; e++) begin
      pe = !((e == 11) || (e == 12) || (e == 23) || (e == 24) || (e == 26));
      pd = 1'b0;
      if (e <= 10) pd = fd[e-1];
      else if ((e >= 13) && (e <= 22)) pd = fm[e-13];
      chk_cnt++; if (rec_progen[e] !== pe) $display("FAIL max_progen edge %0d got %b want %b", e, rec_progen[e], pe); else pass_cnt++;
      chk_cnt++; if (rec_progdata[e] !== pd) $display("FAIL max_progdata edge %0d got %b want %b", e, rec_progdata[e], pd); else pass_cnt++;
    end
    chk_cnt++; if (rec_done[35] !== 1'b1) $display("FAIL max_done edge 35 got %b want 1", rec_done[35]); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n_err, n_done;
    n_err  = 0;
    n_done = 0;
    do_reset();
    run_txn(8'd4, 8'd1, 25 + TO + 4, -1, -1, -1, -1, 1'b0);
    for (int e = 1; e <= 25 + TO + 4; e++) begin
      if (rec_error[e] === 1'b1) n_err++;
      if (rec_done[e] === 1'b1) n_done++;
    end
    chk_cnt++; if (rec_error[25+TO] !== 1'b1) $display("FAIL timeout_error_edge got %b want 1", rec_error[25+TO]); else pass_cnt++;
    chk_cnt++; if (n_err !== 1) $display("FAIL timeout_error_count got %0d want 1", n_err); else pass_cnt++;
    chk_cnt++; if (n_done !== 0) $display("FAIL timeout_done_count got %0d want 0", n_done); else pass_cnt++;
    chk_cnt++; if (rec_busy[24+TO] !== 1'b1) $display("FAIL timeout_busy_before got %b want 1", rec_busy[24+TO]); else pass_cnt++;
    chk_cnt++; if (rec_busy[25+TO] !== 1'b0) $display("FAIL timeout_busy_at got %b want 0", rec_busy[25+TO]); else pass_cnt++;
    chk_cnt++; if (rec_busy[29+TO] !== 1'b0) $display("FAIL timeout_busy_after got %b want 0", rec_busy[29+TO]); else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [7:0] mv [2];
    logic [7:0] dv [2];
    int n_err, n_pe, n_busy;
    mv[0] = 8'd1; dv[0] = 8'd5;
    mv[1] = 8'd4; dv[1] = 8'd0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_err = 0; n_pe = 0; n_busy = 0;
      run_txn(mv[k], dv[k], 8, -1, -1, -1, -1, 1'b0);
      for (int e = 1; e <= 8; e++) begin
        if (rec_error[e] === 1'b1) n_err++;
        if (rec_progen[e] !== 1'b0) n_pe++;
        if (rec_busy[e] !== 1'b0) n_busy++;
      end
      chk_cnt++; if (rec_error[1] !== 1'b1) $display("FAIL illegal%0d_error_edge1 got %b want 1", k, rec_error[1]); else pass_cnt++;
      chk_cnt++; if (n_err !== 1) $display("FAIL illegal%0d_error_count got %0d want 1", k, n_err); else pass_cnt++;
      chk_cnt++; if (n_pe !== 0) $display("FAIL illegal%0d_progen_cycles got %0d want 0", k, n_pe); else pass_cnt++;
      chk_cnt++; if (n_busy !== 0) $display("FAIL illegal%0d_busy_cycles got %0d want 0", k, n_busy); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] fd;
    logic [9:0] fm;
    logic pe, pd;
    fd = 10'b0000000001;
    fm = 10'b0000001111;
    do_reset();
    run_txn(8'd255, 8'd255, 17, -1, -1, -1, -1, 1'b0);
    chk_cnt++; if (progen !== 1'b1) $display("FAIL rstmid_progen_before got %b want 1", progen); else pass_cnt++;
    chk_cnt++; if (progdata !== 1'b1) $display("FAIL rstmid_progdata_before got %b want 1", progdata); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    chk_cnt++; if (progen !== 1'b0) $display("FAIL rstmid_progen got %b want 0", progen); else pass_cnt++;
    chk_cnt++; if (progdata !== 1'b0) $display("FAIL rstmid_progdata got %b want 0", progdata); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk_cnt++; if (progen !== 1'b0) $display("FAIL rstmid_progen_after_release got %b want 0", progen); else pass_cnt++;
    run_txn(8'd4, 8'd1, 30, -1, -1, -1, -1, 1'b0);
    for (int e = 1; e <= 25; e++) begin
      pe = ((e >= 1) && (e <= 10)) || ((e >= 13) && (e <= 22)) || (e == 25);
      pd = 1'b0;
      if (e <= 10) pd = fd[e-1];
      else if ((e >= 13) && (e <= 22)) pd = fm[e-13];
      chk_cnt++; if (rec_progen[e] !== pe) $display("FAIL rstmid_seq_progen edge %0d got %b want %b", e, rec_progen[e], pe); else pass_cnt++;
      chk_cnt++; if (rec_progdata[e] !== pd) $display("FAIL rstmid_seq_progdata edge %0d got %b want %b", e, rec_progdata[e], pd); else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    logic [9:0] fd;
    logic [9:0] fm;
    logic pd;
    int n_done;
    fd = 10'b0000000001;
    fm = 10'b0000001111;
    n_done = 0;
    do_reset();
    run_txn(8'd4, 8'd1, 95, 27, 77, 5, 30, 1'b0);
    for (int e = 1; e <= 95; e++) if (rec_done[e] === 1'b1) n_done++;
    chk_cnt++; if (n_done !== 1) $display("FAIL ignore_done_count got %0d want 1", n_done); else pass_cnt++;
    chk_cnt++; if (rec_done[80] !== 1'b1) $display("FAIL ignore_done_edge80 got %b want 1", rec_done[80]); else pass_cnt++;
    chk_cnt++; if (rec_busy[85] !== 1'b0) $display("FAIL ignore_busy_85 got %b want 0", rec_busy[85]); else pass_cnt++;
    chk_cnt++; if (rec_busy[95] !== 1'b0) $display("FAIL ignore_busy_95 got %b want 0", rec_busy[95]); else pass_cnt++;
    for (int e = 1; e <= 22; e++) begin
      if ((e == 11) || (e == 12)) continue;
      pd = (e <= 10) ? fd[e-1] : fm[e-13];
      chk_cnt++; if (rec_progdata[e] !== pd) $display("FAIL ignore_progdata edge %0d got %b want %b", e, rec_progdata[e], pd); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_txn(8'd4, 8'd1, 85, 27, 77, -1, -1, 1'b1);
    chk_cnt++; if (rec_done[80] !== 1'b1) $display("FAIL b2b_done_80 got %b want 1", rec_done[80]); else pass_cnt++;
    chk_cnt++; if (rec_busy[80] !== 1'b0) $display("FAIL b2b_busy_80 got %b want 0", rec_busy[80]); else pass_cnt++;
    chk_cnt++; if (rec_busy[81] !== 1'b0) $display("FAIL b2b_busy_81 got %b want 0", rec_busy[81]); else pass_cnt++;
    chk_cnt++; if (rec_busy[82] !== 1'b1) $display("FAIL b2b_busy_82 got %b want 1", rec_busy[82]); else pass_cnt++;
    chk_cnt++; if (rec_progen[82] !== 1'b1) $display("FAIL b2b_progen_82 got %b want 1", rec_progen[82]); else pass_cnt++;
    chk_cnt++; if (rec_progdata[82] !== 1'b1) $display("FAIL b2b_progdata_82 got %b want 1", rec_progdata[82]); else pass_cnt++;
    chk_cnt++; if (rec_progdata[83] !== 1'b0) $display("FAIL b2b_progdata_83 got %b want 0", rec_progdata[83]); else pass_cnt++;
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    progdone = 1'b1;
    multiply = 8'd4;
    divide   = 8'd1;
    test_reset();
    test_basic();
    test_max();
    test_illegal();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
